towers_hit_manager: RTL

Consumes the per-pixel drawing requests of the falling-towers layer and the player layer. Detects player/tower overlap once per frame and maintains the lives count, the post-hit freeze and invulnerability windows, game-over and a survival score. Drives the pause input of the towers mover, so it sits directly downstream of the towers drawing path and upstream of the towers pause control.

---
 rtl/towers_hit_manager.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/towers_hit_manager.sv
// ---------------------------------------------------------------------------
// towers_hit_manager
//
// Purpose:
//   Watches the per-pixel drawing requests of the falling-towers layer and
//   the player layer. Any pixel where both layers draw marks an overlap for
//   the current frame. At each start-of-frame that is not paused, the frame
//   that just ended is judged:
//     PLAY   : an overlap costs one life and starts the post-hit freeze.
//              A clean frame adds one to the survival score.
//     FREEZE : the towers are held still. Overlaps are ignored. The score
//              does not change.
//     INVULN : the towers move again. Overlaps are still ignored. The score
//              counts up.
//     OVER   : nothing changes until restart.
//   restart overrides everything, including a start-of-frame on the same
//   cycle.
//
// Ports:
//   clk           in   system clock
//   resetN        in   asynchronous active-low reset
//   startOfFrame  in   one-cycle pulse at frame start (frame decisions)
//   playerDR      in   player layer drawing request, current pixel
//   towersDR      in   towers layer drawing request, current pixel
//   userPause     in   user pause level; a paused SOF is not evaluated
//   restart       in   one-cycle new-game request (highest priority)
//   collision     out  one-cycle registered pulse when a hit is accepted
//   lives         out  remaining lives (registered)
//   invulnerable  out  high in FREEZE and INVULN (registered)
//   gameOver      out  high in OVER (registered)
//   towersPause   out  combinational: userPause | FREEZE | OVER
//   score         out  frames survived, saturating at all-ones
//
// Handshake: none. startOfFrame and restart are single-cycle strobes, and
// the pixel requests are sampled on every clock.
// ---------------------------------------------------------------------------
module towers_hit_manager #(
    parameter int START_LIVES       = 3,
    parameter int HIT_FREEZE_FRAMES = 30,
    parameter int INVULN_FRAMES     = 60,
    parameter int SCORE_WIDTH       = 16
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic                   playerDR,
    input  logic                   towersDR,
    input  logic                   userPause,
    input  logic                   restart,
    output logic                   collision,
    output logic [2:0]             lives,
    output logic                   invulnerable,
    output logic                   gameOver,
    output logic                   towersPause,
    output logic [SCORE_WIDTH-1:0] score
);

    // The frame counter must hold the larger of the two window lengths.
    localparam int MAX_FRAMES = (HIT_FREEZE_FRAMES > INVULN_FRAMES) ?
                                HIT_FREEZE_FRAMES : INVULN_FRAMES;
    localparam int CNT_W      = (MAX_FRAMES < 2) ? 1 : $clog2(MAX_FRAMES + 1);

    localparam logic [CNT_W-1:0]       FREEZE_LOAD = CNT_W'(HIT_FREEZE_FRAMES);
    localparam logic [CNT_W-1:0]       INVULN_LOAD = CNT_W'(INVULN_FRAMES);
    localparam logic [CNT_W-1:0]       CNT_ONE     = CNT_W'(1);
    localparam logic [2:0]             LIVES_INIT  = 3'(START_LIVES);
    localparam logic [SCORE_WIDTH-1:0] SCORE_ONE   = SCORE_WIDTH'(1);
    localparam logic [SCORE_WIDTH-1:0] SCORE_MAX   = '1;

    typedef enum logic [1:0] {
        ST_PLAY   = 2'd0,
        ST_FREEZE = 2'd1,
        ST_INVULN = 2'd2,
        ST_OVER   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             lives_q, lives_d;
    logic [CNT_W-1:0]       frame_cnt_q, frame_cnt_d;
    logic [SCORE_WIDTH-1:0] score_q, score_d;
    logic                   overlap_seen_q, overlap_seen_d;
    logic                   collision_q, collision_d;
    logic                   invulnerable_q, invulnerable_d;
    logic                   game_over_q, game_over_d;

    logic                   overlap_now;
    logic                   evaluate;
    logic [SCORE_WIDTH-1:0] score_inc;

    assign overlap_now = playerDR & towersDR;
    assign evaluate    = startOfFrame & ~userPause;
    assign score_inc   = (score_q == SCORE_MAX) ? score_q : (score_q + SCORE_ONE);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        lives_d        = lives_q;
        frame_cnt_d    = frame_cnt_q;
        score_d        = score_q;
        collision_d    = 1'b0;

        // The overlap flag covers one frame. An evaluated SOF closes the old
        // frame and opens a new one, so the SOF cycle's own pixel is the
        // first sample of the new frame. A paused SOF does not close the
        // frame, so the flag keeps accumulating.
        if (evaluate) begin
            overlap_seen_d = overlap_now;
        end else begin
            overlap_seen_d = overlap_seen_q | overlap_now;
        end

        if (restart) begin
            state_d        = ST_PLAY;
            lives_d        = LIVES_INIT;
            frame_cnt_d    = '0;
            score_d        = '0;
            overlap_seen_d = 1'b0;
        end else if (evaluate) begin
            case (state_q)
                ST_PLAY: begin
                    if (overlap_seen_q) begin
                        collision_d = 1'b1;
                        if (lives_q <= 3'd1) begin
                            lives_d     = 3'd0;
                            state_d     = ST_OVER;
                            frame_cnt_d = '0;
                        end else begin
                            lives_d = lives_q - 3'd1;
                            if (HIT_FREEZE_FRAMES > 0) begin
                                state_d     = ST_FREEZE;
                                frame_cnt_d = FREEZE_LOAD;
                            end else if (INVULN_FRAMES > 0) begin
                                state_d     = ST_INVULN;
                                frame_cnt_d = INVULN_LOAD;
                            end else begin
                                state_d     = ST_PLAY;
                                frame_cnt_d = '0;
                            end
                        end
                    end else begin
                        score_d = score_inc;
                    end
                end

                ST_FREEZE: begin
                    // Counter values of 1 or less end the window. This
                    // guards against a wrap if the counter were ever 0.
                    if (frame_cnt_q <= CNT_ONE) begin
                        if (INVULN_FRAMES > 0) begin
                            state_d     = ST_INVULN;
                            frame_cnt_d = INVULN_LOAD;
                        end else begin
                            state_d     = ST_PLAY;
                            frame_cnt_d = '0;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q - CNT_ONE;
                    end
                end

                ST_INVULN: begin
                    score_d = score_inc;
                    if (frame_cnt_q <= CNT_ONE) begin
                        state_d     = ST_PLAY;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q - CNT_ONE;
                    end
                end

                default: begin
                    // ST_OVER: frozen until restart.
                    lives_d = 3'd0;
                end
            endcase
        end

        // The status outputs follow the state being entered, so they change
        // on the same edge as the state.
        invulnerable_d = (state_d == ST_FREEZE) || (state_d == ST_INVULN);
        game_over_d    = (state_d == ST_OVER);
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q        <= ST_PLAY;
            lives_q        <= LIVES_INIT;
            frame_cnt_q    <= '0;
            score_q        <= '0;
            overlap_seen_q <= 1'b0;
            collision_q    <= 1'b0;
            invulnerable_q <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            lives_q        <= lives_d;
            frame_cnt_q    <= frame_cnt_d;
            score_q        <= score_d;
            overlap_seen_q <= overlap_seen_d;
            collision_q    <= collision_d;
            invulnerable_q <= invulnerable_d;
            game_over_q    <= game_over_d;
        end
    end

    assign collision    = collision_q;
    assign lives        = lives_q;
    assign invulnerable = invulnerable_q;
    assign gameOver     = game_over_q;
    assign score        = score_q;

    // The pause must act in the same cycle as the user pause input, so it is
    // combinational from the registered state.
    assign towersPause  = userPause || (state_q == ST_FREEZE) || (state_q == ST_OVER);

endmodule
